// File: rtl/iter_divmod.sv
// Multi-cycle unsigned divide/modulo using radix-2 restoring division.
// Produces one quotient bit per clock under a Start/done handshake.
module iter_divmod #(
    parameter int DATAWIDTH = 64
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Start,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] c,
    output logic                 busy,
    output logic                 done,
    output logic [DATAWIDTH-1:0] quot,
    output logic [DATAWIDTH-1:0] rem,
    output logic                 divzero
);

    // state | meaning
    // IDLE  | waiting for Start
    // CALC  | iterating, one quotient bit per edge
    // DONE  | one-cycle result pulse; Start here is accepted back-to-back

    localparam int CW = $clog2(DATAWIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [DATAWIDTH-1:0]   dvd_q, dvd_d;
    logic [DATAWIDTH-1:0]   dvs_q, dvs_d;
    logic [DATAWIDTH-1:0]   r_q, r_d;
    logic [DATAWIDTH-1:0]   quot_q, quot_d;
    logic [DATAWIDTH-1:0]   rem_q, rem_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   divzero_q, divzero_d;

    logic [DATAWIDTH:0]     r_shift;
    logic [DATAWIDTH-1:0]   r_sub;
    logic [DATAWIDTH-1:0]   r_next;
    logic [DATAWIDTH-1:0]   dvd_next;
    logic                   ge;

    // Compare is one bit wider so a divisor with its MSB set is handled;
    // the subtraction result always fits in DATAWIDTH bits when ge is true.
    always_comb begin
        r_shift  = {r_q, dvd_q[DATAWIDTH-1]};
        ge       = (r_shift >= {1'b0, dvs_q});
        r_sub    = r_shift[DATAWIDTH-1:0] - dvs_q;
        r_next   = ge ? r_sub : r_shift[DATAWIDTH-1:0];
        dvd_next = {dvd_q[DATAWIDTH-2:0], ge};
    end

    always_comb begin
        state_d   = state_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        r_d       = r_q;
        cnt_d     = cnt_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        divzero_d = divzero_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) begin
                    state_d = IDLE;
                end
                if (Start) begin
                    dvd_d = a;
                    dvs_d = c;
                    r_d   = '0;
                    if (c == '0) begin
                        state_d   = DONE;
                        quot_d    = '1;
                        rem_d     = a;
                        divzero_d = 1'b1;
                    end else begin
                        state_d = CALC;
                        cnt_d   = CW'(DATAWIDTH);
                    end
                end
            end
            CALC: begin
                // Quotient bits accumulate in the low end of the dividend register.
                r_d   = r_next;
                dvd_d = dvd_next;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d   = DONE;
                    quot_d    = dvd_next;
                    rem_d     = r_next;
                    divzero_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= IDLE;
            dvd_q     <= '0;
            dvs_q     <= '0;
            r_q       <= '0;
            cnt_q     <= '0;
            quot_q    <= '0;
            rem_q     <= '0;
            divzero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            r_q       <= r_d;
            cnt_q     <= cnt_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            divzero_q <= divzero_d;
        end
    end

    assign busy    = (state_q == CALC);
    assign done    = (state_q == DONE);
    assign quot    = quot_q;
    assign rem     = rem_q;
    assign divzero = divzero_q;

endmodule

// File: tb/tb_iter_divmod.sv
// Bench for iter_divmod: transaction-level model with per-cycle compare on a
// 64-bit instance, directed literal checks, and random checks on an 8-bit instance.
module tb_iter_divmod;

    logic        clk;
    logic        rst;
    logic        start;
    logic [63:0] a, c;
    logic        busy, done, divzero;
    logic [63:0] quot, rem;

    logic        start8;
    logic [7:0]  a8, c8;
    logic        busy8, done8, divzero8;
    logic [7:0]  quot8, rem8;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    iter_divmod #(.DATAWIDTH(64)) dut (
        .Clk(clk), .Rst(rst), .Start(start), .a(a), .c(c),
        .busy(busy), .done(done), .quot(quot), .rem(rem), .divzero(divzero)
    );

    iter_divmod #(.DATAWIDTH(8)) dut8 (
        .Clk(clk), .Rst(rst), .Start(start8), .a(a8), .c(c8),
        .busy(busy8), .done(done8), .quot(quot8), .rem(rem8), .divzero(divzero8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: result is plain / and %, ready 64 edges after acceptance.
    logic        m_busy, m_done, m_dz;
    logic [63:0] m_quot, m_rem, p_q, p_r;
    int          done_at;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_dz   <= 1'b0;
            m_quot <= '0;
            m_rem  <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (cyc == done_at) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_quot <= p_q;
                    m_rem  <= p_r;
                    m_dz   <= 1'b0;
                end
            end else if (start) begin
                if (c == 64'd0) begin
                    m_done <= 1'b1;
                    m_quot <= '1;
                    m_rem  <= a;
                    m_dz   <= 1'b1;
                end else begin
                    m_busy  <= 1'b1;
                    done_at <= cyc + 64;
                    p_q     <= a / c;
                    p_r     <= a % c;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("busy", {63'd0, busy}, {63'd0, m_busy});
            chk("done", {63'd0, done}, {63'd0, m_done});
            chk("quot", quot, m_quot);
            chk("rem", rem, m_rem);
            chk("divzero", {63'd0, divzero}, {63'd0, m_dz});
            chk("busy_done_excl", {63'd0, busy & done}, 64'd0);
        end
    end

    task automatic wait_done(output int n);
        n = 1;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Called at a negedge; returns at a negedge after the done cycle.
    task automatic op64(input logic [63:0] av, input logic [63:0] cv,
                        input logic [63:0] eq, input logic [63:0] er,
                        input logic edz, input string nm);
        int n;
        start = 1'b1; a = av; c = cv;
        @(negedge clk);
        start = 1'b0; a = {$urandom, $urandom}; c = {$urandom, $urandom};
        wait_done(n);
        chk({nm, "_lat"}, 64'(n - 1), (cv == 64'd0) ? 64'd0 : 64'd64);
        chk({nm, "_quot"}, quot, eq);
        chk({nm, "_rem"}, rem, er);
        chk({nm, "_dz"}, {63'd0, divzero}, {63'd0, edz});
        @(negedge clk);
    endtask

    task automatic op8(input logic [7:0] av, input logic [7:0] cv);
        int n;
        start8 = 1'b1; a8 = av; c8 = cv;
        @(negedge clk);
        start8 = 1'b0; a8 = 8'($urandom); c8 = 8'($urandom);
        n = 1;
        while (!done8 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("w8_lat", 64'(n - 1), (cv == 8'd0) ? 64'd0 : 64'd8);
        chk("w8_quot", {56'd0, quot8}, (cv == 8'd0) ? 64'hFF : {56'd0, av / cv});
        chk("w8_rem", {56'd0, rem8}, (cv == 8'd0) ? {56'd0, av} : {56'd0, av % cv});
        chk("w8_dz", {63'd0, divzero8}, {63'd0, cv == 8'd0});
        @(negedge clk);
    endtask

    initial begin
        int n;
        logic [63:0] ra, rc;
        rst = 1'b1; start = 1'b0; a = '0; c = '0;
        start8 = 1'b0; a8 = '0; c8 = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_quot", quot, 64'd0);
        chk("rst_rem", rem, 64'd0);
        chk("rst_dz", {63'd0, divzero}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        op64(64'd100, 64'd7, 64'd14, 64'd2, 1'b0, "t1");
        repeat (3) @(negedge clk);
        chk("t1_hold_quot", quot, 64'd14);
        chk("t1_hold_rem", rem, 64'd2);

        op64(64'd3, 64'd10, 64'd0, 64'd3, 1'b0, "t2_small");
        op64(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, "t2_max");
        op64(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd1, 64'd0, 1'b0, "t2_eq");
        op64(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 64'd1, 1'b0, "t2_msb");
        op64(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'd1,
             64'h7FFF_FFFF_FFFF_FFFF, 1'b0, "t2_msb2");

        op64(64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1'b1, "t3_dz");
        op64(64'd9, 64'd4, 64'd2, 64'd1, 1'b0, "t3_after");

        // Start during CALC is ignored; Start in the DONE cycle is accepted.
        start = 1'b1; a = 64'd100; c = 64'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        start = 1'b1; a = 64'd50; c = 64'd6;
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        chk("t4_first_quot", quot, 64'd14);
        chk("t4_first_rem", rem, 64'd2);
        start = 1'b1; a = 64'd50; c = 64'd6;
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        chk("t4_b2b_lat", 64'(n - 1), 64'd64);
        chk("t4_b2b_quot", quot, 64'd8);
        chk("t4_b2b_rem", rem, 64'd2);
        @(negedge clk);

        // Asynchronous reset in the middle of CALC.
        start = 1'b1; a = 64'd100; c = 64'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t5_async_busy", {63'd0, busy}, 64'd0);
        chk("t5_async_done", {63'd0, done}, 64'd0);
        chk("t5_async_quot", quot, 64'd0);
        chk("t5_async_rem", rem, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (70) @(negedge clk);
        chk("t5_no_late_quot", quot, 64'd0);
        op64(64'd1000, 64'd33, 64'd30, 64'd10, 1'b0, "t5_restart");

        for (int i = 0; i < 20; i++) begin
            ra = {$urandom, $urandom};
            rc = {$urandom, $urandom} >> $urandom_range(0, 63);
            if (rc == 64'd0) rc = 64'd1;
            op64(ra, rc, ra / rc, ra % rc, 1'b0, "rnd64");
        end

        op8(8'd200, 8'd13);
        chk("t6_lit_quot", {56'd0, quot8}, 64'd15);
        chk("t6_lit_rem", {56'd0, rem8}, 64'd5);
        for (int i = 0; i < 1000; i++) begin
            op8(8'($urandom), 8'($urandom_range(0, 255)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
